// File: rtl/hwpe_ctrl_offload_master_pkg.sv
// Shared control definitions for the HWPE offload initiator.
// Register map indices, FSM encodings and the job descriptor type.
package hwpe_ctrl_offload_master_pkg;

   localparam int unsigned REGFILE_TRIGGER_IDX   = 0;
   localparam int unsigned REGFILE_ACQUIRE_IDX   = 1;
   localparam int unsigned REGFILE_SOFTCLEAR_IDX = 5;
   localparam int unsigned MAX_JOB_REGS          = 16;

   typedef enum logic [3:0] {
      OFF_IDLE,
      OFF_ACQ,
      OFF_BACKOFF,
      OFF_WRITE,
      OFF_TRIG,
      OFF_WAIT,
      OFF_DONE,
      OFF_ABORT,
      OFF_CLR
   } offload_state_t;

   typedef enum logic [1:0] {
      TXN_IDLE,
      TXN_REQ,
      TXN_RSP
   } txn_state_t;

   typedef logic [MAX_JOB_REGS-1:0][31:0] offload_job_t;

   function automatic logic [31:0] reg_addr(input logic [29:0] idx);
      return {idx, 2'b00};
   endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral control port between an initiator and an HWPE target.
// Request channel held until gnt; response tagged with r_id.
interface hwpe_ctrl_intf_periph #(
   parameter int unsigned ID_WIDTH = 16
) ();

   logic                req;
   logic [31:0]         add;
   logic                wen;
   logic [3:0]          be;
   logic [31:0]         data;
   logic [ID_WIDTH-1:0] id;
   logic                gnt;
   logic [31:0]         r_data;
   logic                r_valid;
   logic [ID_WIDTH-1:0] r_id;

   modport master (
      output req, add, wen, be, data, id,
      input  gnt, r_data, r_valid, r_id
   );

   modport slave (
      input  req, add, wen, be, data, id,
      output gnt, r_data, r_valid, r_id
   );

endinterface

// File: rtl/hwpe_ctrl_periph_txn.sv
// Single-transaction engine: holds the request until gnt, then waits
// for the response carrying our id. A new start may overlap done_o.
import hwpe_ctrl_offload_master_pkg::*;

module hwpe_ctrl_periph_txn #(
   parameter int unsigned ID_WIDTH = 16,
   parameter int unsigned CORE_ID  = 0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [31:0]         add_i,
   input  logic                wen_i,
   input  logic [31:0]         data_i,
   output logic                done_o,
   output logic [31:0]         rdata_o,
   output logic                req,
   output logic [31:0]         add,
   output logic                wen,
   output logic [3:0]          be,
   output logic [31:0]         data,
   output logic [ID_WIDTH-1:0] id,
   input  logic                gnt,
   input  logic [31:0]         r_data,
   input  logic                r_valid,
   input  logic [ID_WIDTH-1:0] r_id
);

   localparam logic [ID_WIDTH-1:0] OWN_ID = ID_WIDTH'(1) << CORE_ID;

   txn_state_t st_q;
   logic       launch;

   assign done_o  = (st_q == TXN_RSP) && r_valid && (r_id == id);
   assign rdata_o = r_data;
   assign launch  = start_i && ((st_q == TXN_IDLE) || done_o);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q <= TXN_IDLE;
         req  <= 1'b0;
         add  <= '0;
         wen  <= 1'b1;
         be   <= '0;
         data <= '0;
         id   <= '0;
      end else if (launch) begin
         st_q <= TXN_REQ;
         req  <= 1'b1;
         add  <= add_i;
         wen  <= wen_i;
         be   <= 4'hF;
         data <= data_i;
         id   <= OWN_ID;
      end else begin
         unique case (st_q)
            TXN_IDLE: ;
            TXN_REQ: begin
               if (gnt) begin
                  req  <= 1'b0;
                  st_q <= TXN_RSP;
               end
            end
            TXN_RSP: begin
               if (done_o) st_q <= TXN_IDLE;
            end
            default: st_q <= TXN_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/hwpe_ctrl_offload_master.sv
// Offload initiator: acquire context, program job words, trigger,
// then wait for the completion event from the HWPE target.
import hwpe_ctrl_offload_master_pkg::*;

module hwpe_ctrl_offload_master #(
   parameter int unsigned N_JOB_REGS     = 4,
   parameter int unsigned JOB_REG_OFFSET = 8,
   parameter int unsigned ID_WIDTH       = 16,
   parameter int unsigned CORE_ID        = 0,
   parameter int unsigned BACKOFF_CYCLES = 8,
   parameter int unsigned MAX_RETRIES    = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   hwpe_ctrl_intf_periph.master       periph,
   input  logic                       job_valid_i,
   output logic                       job_ready_o,
   input  logic [N_JOB_REGS-1:0][31:0] job_regs_i,
   input  logic                       clear_req_i,
   input  logic                       evt_i,
   output logic                       done_o,
   output logic                       abort_o,
   output logic [7:0]                 ctx_id_o,
   output logic                       busy_o
);

   offload_state_t state_q, state_d;
   offload_job_t   job_q;
   logic [7:0]     retry_q;
   logic [15:0]    bo_q;
   logic [3:0]     wr_q;
   logic [3:0]     wr_nxt;

   logic           issue;
   logic [29:0]    t_idx;
   logic           t_wen;
   logic [31:0]    t_data;
   logic           txn_done;
   logic [31:0]    txn_rdata;
   logic           rdata_unused;
   logic           accept;
   logic           give_up;

   assign accept  = job_valid_i && job_ready_o;
   assign wr_nxt  = wr_q + 4'd1;
   assign give_up = ({1'b0, retry_q} + 9'd1) >= 9'(MAX_RETRIES);
   assign rdata_unused = ^txn_rdata[30:8];

   hwpe_ctrl_periph_txn #(
      .ID_WIDTH (ID_WIDTH),
      .CORE_ID  (CORE_ID)
   ) u_txn (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (issue),
      .add_i   (reg_addr(t_idx)),
      .wen_i   (t_wen),
      .data_i  (t_data),
      .done_o  (txn_done),
      .rdata_o (txn_rdata),
      .req     (periph.req),
      .add     (periph.add),
      .wen     (periph.wen),
      .be      (periph.be),
      .data    (periph.data),
      .id      (periph.id),
      .gnt     (periph.gnt),
      .r_data  (periph.r_data),
      .r_valid (periph.r_valid),
      .r_id    (periph.r_id)
   );

   // Next request is issued in the same cycle its predecessor retires.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      t_idx   = '0;
      t_wen   = 1'b1;
      t_data  = '0;
      unique case (state_q)
         OFF_IDLE: begin
            if (accept) begin
               state_d = OFF_ACQ;
               issue   = 1'b1;
               t_idx   = 30'(REGFILE_ACQUIRE_IDX);
            end else if (clear_req_i) begin
               state_d = OFF_CLR;
               issue   = 1'b1;
               t_idx   = 30'(REGFILE_SOFTCLEAR_IDX);
               t_wen   = 1'b0;
            end
         end
         OFF_ACQ: begin
            if (txn_done) begin
               if (txn_rdata[31]) begin
                  state_d = give_up ? OFF_ABORT : OFF_BACKOFF;
               end else begin
                  state_d = OFF_WRITE;
                  issue   = 1'b1;
                  t_idx   = 30'(JOB_REG_OFFSET);
                  t_wen   = 1'b0;
                  t_data  = job_q[0];
               end
            end
         end
         OFF_BACKOFF: begin
            if (bo_q == 16'(BACKOFF_CYCLES - 1)) begin
               state_d = OFF_ACQ;
               issue   = 1'b1;
               t_idx   = 30'(REGFILE_ACQUIRE_IDX);
            end
         end
         OFF_WRITE: begin
            if (txn_done) begin
               issue = 1'b1;
               t_wen = 1'b0;
               if (wr_q == 4'(N_JOB_REGS - 1)) begin
                  state_d = OFF_TRIG;
                  t_idx   = 30'(REGFILE_TRIGGER_IDX);
               end else begin
                  t_idx  = 30'(JOB_REG_OFFSET) + 30'(wr_nxt);
                  t_data = job_q[wr_nxt];
               end
            end
         end
         OFF_TRIG:  if (txn_done) state_d = OFF_WAIT;
         OFF_WAIT:  if (evt_i) state_d = OFF_DONE;
         OFF_DONE:  state_d = OFF_IDLE;
         OFF_ABORT: state_d = OFF_IDLE;
         OFF_CLR:   if (txn_done) state_d = OFF_IDLE;
         default:   state_d = OFF_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= OFF_IDLE;
         job_q       <= '0;
         retry_q     <= '0;
         bo_q        <= '0;
         wr_q        <= '0;
         ctx_id_o    <= '0;
         done_o      <= 1'b0;
         abort_o     <= 1'b0;
         busy_o      <= 1'b0;
         job_ready_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_o      <= (state_d != OFF_IDLE);
         job_ready_o <= (state_d == OFF_IDLE);
         done_o      <= (state_d == OFF_DONE) || (state_d == OFF_ABORT);
         abort_o     <= (state_d == OFF_ABORT);
         unique case (state_q)
            OFF_IDLE: begin
               if (accept) begin
                  for (int k = 0; k < N_JOB_REGS; k++) job_q[k] <= job_regs_i[k];
                  retry_q <= '0;
               end
            end
            OFF_ACQ: begin
               if (txn_done && txn_rdata[31]) begin
                  if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
                  bo_q <= '0;
               end else if (txn_done) begin
                  ctx_id_o <= txn_rdata[7:0];
                  wr_q     <= '0;
               end
            end
            OFF_BACKOFF: bo_q <= bo_q + 16'd1;
            OFF_WRITE:   if (txn_done) wr_q <= wr_nxt;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_offload_master.sv
// Scoreboarded bench: a target model answers requests; a monitor pops
// expected transactions on every grant and checks outputs.
module tb_hwpe_ctrl_offload_master;

   typedef struct packed {
      logic [31:0] add;
      logic        wen;
      logic [31:0] data;
   } txn_t;

   logic              clk;
   logic              rst_n;
   logic              job_valid;
   logic              job_ready;
   logic [3:0][31:0]  job_regs;
   logic              clear_req;
   logic              evt;
   logic              done;
   logic              abort;
   logic [7:0]        ctx_id;
   logic              busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   txn_t        exp_q[$];
   logic [31:0] acq_resp[$];
   int          gaps[$];

   int txn_cnt      = 0;
   int stall_on_txn = -1;
   int bad_on_txn   = -1;
   int stall_len    = 0;
   int hold         = 0;
   int req_len      = 0;
   int idle_run     = 0;
   int trig_cyc     = 0;
   int acc_cyc      = 0;
   logic req_prev   = 1'b0;
   logic trig_seen  = 1'b0;

   logic [31:0]       resp_v;
   logic              pend;
   logic [15:0]       pend_id;
   logic [31:0]       pend_data;

   hwpe_ctrl_intf_periph #(.ID_WIDTH(16)) periph ();

   hwpe_ctrl_offload_master #(
      .N_JOB_REGS     (4),
      .JOB_REG_OFFSET (8),
      .ID_WIDTH       (16),
      .CORE_ID        (0),
      .BACKOFF_CYCLES (8),
      .MAX_RETRIES    (3)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .periph      (periph.master),
      .job_valid_i (job_valid),
      .job_ready_o (job_ready),
      .job_regs_i  (job_regs),
      .clear_req_i (clear_req),
      .evt_i       (evt),
      .done_o      (done),
      .abort_o     (abort),
      .ctx_id_o    (ctx_id),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic w,
                       input logic [31:0] d);
      txn_t t;
      t.add  = a;
      t.wen  = w;
      t.data = d;
      exp_q.push_back(t);
   endtask

   // Monitor and grant generator, active on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         req_prev   = 1'b0;
         hold       = 0;
         periph.gnt = 1'b0;
         idle_run   = 0;
      end else begin
         if (periph.req) begin
            if (!req_prev) begin
               txn_cnt++;
               req_len = 0;
               if (txn_cnt == stall_on_txn) hold = 5;
               if (periph.add == 32'h4 && periph.wen) gaps.push_back(idle_run);
               if (periph.add == 32'h0 && !periph.wen) trig_cyc = cyc;
            end else if (exp_q.size() > 0) begin
               check("hold_add", periph.add, exp_q[0].add);
               check("hold_data", periph.data, exp_q[0].data);
            end
            req_len++;
            idle_run = 0;
            if (hold > 0) begin
               periph.gnt = 1'b0;
               hold--;
            end else begin
               periph.gnt = 1'b1;
               if (txn_cnt == stall_on_txn) stall_len = req_len;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_txn act=%h/%b exp=none",
                           periph.add, periph.wen);
               end else begin
                  txn_t e;
                  e = exp_q.pop_front();
                  check("txn_add", periph.add, e.add);
                  check("txn_wen", 32'(periph.wen), 32'(e.wen));
                  check("txn_data", periph.data, e.data);
                  check("txn_be", 32'(periph.be), 32'hF);
                  check("txn_id", 32'(periph.id), 32'h1);
               end
               if (periph.add == 32'h0 && !periph.wen) trig_seen = 1'b1;
            end
         end else begin
            periph.gnt = 1'b0;
            if (periph.r_valid) idle_run = 0;
            else idle_run++;
         end
         req_prev = periph.req;
      end
   end

   // Target response: one cycle after grant, optionally preceded by a
   // response with a foreign id that must be ignored.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         periph.r_valid <= 1'b0;
         periph.r_id    <= '0;
         periph.r_data  <= '0;
         pend           <= 1'b0;
         pend_id        <= '0;
         pend_data      <= '0;
      end else if (pend) begin
         periph.r_valid <= 1'b1;
         periph.r_id    <= pend_id;
         periph.r_data  <= pend_data;
         pend           <= 1'b0;
      end else if (periph.req && periph.gnt) begin
         resp_v = 32'h0;
         if (periph.add == 32'h4 && periph.wen)
            resp_v = (acq_resp.size() > 0) ? acq_resp.pop_front() : 32'h2;
         periph.r_valid <= 1'b1;
         if (txn_cnt == bad_on_txn) begin
            periph.r_id   <= ~periph.id;
            periph.r_data <= 32'hFFFF_FFFF;
            pend          <= 1'b1;
            pend_id       <= periph.id;
            pend_data     <= resp_v;
         end else begin
            periph.r_id   <= periph.id;
            periph.r_data <= resp_v;
         end
      end else begin
         periph.r_valid <= 1'b0;
      end
   end

   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   task automatic run_job(input logic [3:0][31:0] w, input int n_busy,
                          input logic ab, input logic [7:0] ctx,
                          input logic do_evt, input logic with_clr);
      int n;
      for (int i = 0; i < n_busy; i++) acq_resp.push_back(32'hFFFF_FFFF);
      if (!ab) acq_resp.push_back({24'h0, ctx});
      for (int i = 0; i < n_busy + (ab ? 0 : 1); i++) push(32'h4, 1'b1, 32'h0);
      if (!ab) begin
         for (int k = 0; k < 4; k++) push(32'((8 + k) * 4), 1'b0, w[k]);
         push(32'h0, 1'b0, 32'h0);
      end
      trig_seen = 1'b0;
      nstep();
      job_valid = 1'b1;
      clear_req = with_clr;
      job_regs  = w;
      n = 0;
      while (!job_ready && n < 50) begin
         nstep();
         n++;
      end
      check("accept_timeout", 32'(n >= 50), 32'h0);
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      job_valid = 1'b0;
      clear_req = 1'b0;
      n = 0;
      if (ab) begin
         while (!done && n < 300) begin
            nstep();
            n++;
         end
         check("abort_timeout", 32'(n >= 300), 32'h0);
         check("abort_flag", 32'(abort), 32'h1);
         nstep();
         check("abort_pulse_end", 32'({done, abort}), 32'h0);
      end else begin
         while (!trig_seen && n < 300) begin
            nstep();
            n++;
         end
         check("trig_timeout", 32'(n >= 300), 32'h0);
         nstep();
         nstep();
         check("wait_busy", 32'({busy, done}), 32'h2);
         if (do_evt) begin
            evt = 1'b1;
            nstep();
            evt = 1'b0;
            check("done_pulse", 32'({done, abort}), 32'h2);
            nstep();
            check("done_end", 32'({done, busy}), 32'h0);
            check("ctx_id", 32'(ctx_id), 32'(ctx));
         end
      end
      check("sb_empty", 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      int nb;
      rst_n     = 1'b0;
      job_valid = 1'b0;
      job_regs  = '0;
      clear_req = 1'b0;
      evt       = 1'b0;
      repeat (3) nstep();
      check("rst_outs", 32'({job_ready, busy, done, abort}), 32'h0);
      check("rst_ctx", 32'(ctx_id), 32'h0);
      check("rst_req_wen", 32'({periph.req, periph.wen}), 32'h1);
      check("rst_add", periph.add, 32'h0);
      check("rst_data", periph.data, 32'h0);
      check("rst_be_id", 32'({periph.be, periph.id}), 32'h0);
      rst_n = 1'b1;
      nstep();
      check("ready_after_rst", 32'(job_ready), 32'h1);

      evt = 1'b1;
      nstep();
      evt = 1'b0;
      nstep();
      check("evt_idle_ignored", 32'({done, busy}), 32'h0);

      run_job({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b0, 8'h02, 1'b1, 1'b0);
      check("trig_latency", 32'(trig_cyc - acc_cyc), 32'd10);

      gaps.delete();
      run_job({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2, 1'b0, 8'h05, 1'b1, 1'b0);
      check("acq_count", 32'(gaps.size()), 32'd3);
      if (gaps.size() == 3) begin
         check("backoff_gap1", 32'(gaps[1]), 32'd8);
         check("backoff_gap2", 32'(gaps[2]), 32'd8);
      end

      run_job({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 3, 1'b1, 8'h00, 1'b1, 1'b0);
      repeat (5) nstep();
      check("abort_no_more", 32'(exp_q.size()), 32'h0);

      stall_on_txn = txn_cnt + 3;
      run_job({32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 1'b0, 8'h02, 1'b1, 1'b0);
      check("stall_req_len", 32'(stall_len), 32'd6);
      stall_on_txn = -1;

      push(32'd20, 1'b0, 32'h0);
      nstep();
      clear_req = 1'b1;
      nstep();
      clear_req = 1'b0;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy) nb++;
         nstep();
      end
      check("clr_busy_cycles", 32'(nb), 32'd2);
      check("clr_sb_empty", 32'(exp_q.size()), 32'h0);

      bad_on_txn = txn_cnt + 1;
      run_job({32'hE3, 32'hE2, 32'hE1, 32'hE0}, 0, 1'b0, 8'h07, 1'b1, 1'b1);
      bad_on_txn = -1;
      repeat (5) nstep();
      check("clr_dropped", 32'({busy, 31'(exp_q.size())}), 32'h0);

      run_job({32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 1'b0, 8'h03, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_outs", 32'({job_ready, busy, done, abort}), 32'h0);
      check("midrst_ctx", 32'(ctx_id), 32'h0);
      check("midrst_req_wen", 32'({periph.req, periph.wen}), 32'h1);
      check("midrst_add_data", periph.add | periph.data, 32'h0);
      nstep();
      rst_n = 1'b1;
      run_job({32'h13, 32'h12, 32'h11, 32'h10}, 1, 1'b0, 8'h04, 1'b1, 1'b0);

      repeat (4) nstep();
      check("final_sb_empty", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hwpe_ctrl_offload_master.md
Name: hwpe_ctrl_offload_master

Overview:
- Initiator side of the peripheral control protocol; offloads one job to an HWPE control target.
- Sequence per job: acquire a context (test&set read), program job registers, write trigger, wait for completion event.
- Sits in core-side or DMA-side test/offload logic. Drives a `hwpe_ctrl_intf_periph.master` port.

Parameters:
- N_JOB_REGS, 4: number of 32-bit job registers written per offload (1..16).
- JOB_REG_OFFSET, 8: register index of first job register (word index, not byte address).
- ID_WIDTH, 16: width of periph id / r_id.
- CORE_ID, 0: bit index set in the one-hot id driven on every request.
- BACKOFF_CYCLES, 8: idle cycles between a busy acquire and its retry (>=1).
- MAX_RETRIES, 255: acquire attempts before abort (8-bit counter).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- periph  master  -  req/add/wen/be/data/id out; gnt/r_data/r_valid/r_id in.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  descriptor accepted (high only in IDLE).
- job_regs_i  in  N_JOB_REGS x 32  descriptor words, sampled on accept.
- clear_req_i  in  1  request soft clear of target (honoured only in IDLE).
- evt_i  in  1  completion event from target (event bit 0 for CORE_ID).
- done_o  out  1  one-cycle pulse when job completes or aborts.
- abort_o  out  1  qualifies done_o: retries exhausted.
- ctx_id_o  out  8  context id returned by acquire; valid from WRITE until next accept.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset: req=0, wen=1, add=0, be=0, data=0, id=0; job_ready_o=0 in reset, 1 after; done_o=0, abort_o=0, ctx_id_o=0, busy_o=0; FSM=IDLE; retry counter=0.
- Transactions:
  - One outstanding at a time.
  - Assert req with add/wen/be/data/id stable until the cycle gnt=1.
  - Deassert req the following cycle.
  - Wait for r_valid with r_id == driven id before the next request.
  - be=4'hF always; id = 1 << CORE_ID; add = {index, 2'b00}.
- FSM states:
  - IDLE:
    - job_valid_i & job_ready_o: latch job_regs_i, retry counter=0 → ACQ.
    - Otherwise, if clear_req_i → CLR.
    - job_valid_i takes priority over clear_req_i in the same cycle; the clear stays pending only if clear_req_i is held.
  - ACQ:
    - Read register 1 (wen=1).
    - On r_valid:
      - r_data[31]=1 (busy): retry counter+1 → BACKOFF, or → ABORT if counter reaches MAX_RETRIES.
      - Otherwise: ctx_id_o = r_data[7:0], word index=0 → WRITE.
  - BACKOFF: count BACKOFF_CYCLES idle cycles with req=0 → ACQ.
  - WRITE:
    - Write job word k to index JOB_REG_OFFSET+k (wen=0).
    - On each r_valid: k+1; after k = N_JOB_REGS-1 → TRIG.
  - TRIG:
    - Write register 0, data 0.
    - On r_valid → WAIT. The target releases its critical section on this write.
  - WAIT: on evt_i=1 → DONE. evt_i arriving in any other state is ignored.
  - DONE: done_o=1 for one cycle → IDLE.
  - ABORT: done_o=1 and abort_o=1 for one cycle → IDLE. No trigger is issued; the target critical section is never entered on busy.
  - CLR: write register 5, data 0; on r_valid → IDLE.
- Latency, zero-wait target (gnt=1 always, r_valid next cycle):
  - Each transaction takes 2 cycles.
  - Uncontended job: accept → trigger req = 2 + 2·N_JOB_REGS cycles.
- Boundaries:
  - gnt held low: request held indefinitely, no timeout.
  - r_valid with mismatching r_id: ignored.
  - N_JOB_REGS=1: WRITE performs a single write.
  - Retry counter saturates, never wraps.
  - Reset mid-transaction: all state returns to reset values immediately. The target is responsible for its own critical-section recovery (soft clear).

Decomposition:
- Add to the shared control package:
  - constants REGFILE_TRIGGER_IDX=0, REGFILE_ACQUIRE_IDX=1, REGFILE_SOFTCLEAR_IDX=5;
  - enum offload_state_t;
  - typedef offload_job_t (N_JOB_REGS words).
- Natural sub-module hwpe_ctrl_periph_txn: single-transaction engine (req/gnt hold, r_valid/r_id match, start_i/done_o/rdata_o). The FSM instantiates it once.

Test Plan:
- Zero-wait target, context free (r_data=0x0000_0002), N_JOB_REGS=4, job words A0..A3 → acquire at index 1, writes at indices 8..11 with A0..A3, trigger at index 0; ctx_id_o=2; trigger req in cycle 10 after accept; done_o pulses 1 cycle after evt_i.
- Target busy twice (r_data=0xFFFF_FFFF), then free → exactly 3 acquires, each retry preceded by 8 req-low cycles; no job writes before the third response.
- MAX_RETRIES=3, always busy → 3 acquires, then done_o=abort_o=1 for one cycle; no write to index 0.
- gnt low for 5 cycles on the second write → add/data stable for all 6 req cycles; exactly one write per index.
- clear_req_i in IDLE → single write to index 5, busy_o high for 2 cycles; clear_req_i and job_valid_i together → job accepted first.
- rst_ni asserted in WAIT → outputs at reset values same cycle; new job after release starts from ACQ.
